// File: rtl/vme_regbank_pkg.sv
// Shared definitions for the VME register bank: address map helpers and
// the register-kind enum used by both the read and write decoders.
package vme_regbank_pkg;

  typedef enum logic [2:0] {
    RK_CTRL,
    RK_STATUS,
    RK_EVT,
    RK_MASK,
    RK_NONE
  } reg_kind_e;

  function automatic int unsigned evt_addr(input int unsigned num_rw,
                                           input int unsigned num_ro);
    return num_rw + num_ro;
  endfunction

  function automatic int unsigned mask_addr(input int unsigned num_rw,
                                            input int unsigned num_ro);
    return evt_addr(num_rw, num_ro) + 1;
  endfunction

  function automatic int unsigned clog2(input int unsigned v);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < v) r++;
    return r;
  endfunction

  function automatic reg_kind_e decode_kind(input int unsigned addr,
                                            input int unsigned num_rw,
                                            input int unsigned num_ro);
    if (addr < num_rw) return RK_CTRL;
    if (addr < num_rw + num_ro) return RK_STATUS;
    if (addr == evt_addr(num_rw, num_ro)) return RK_EVT;
    if (addr == mask_addr(num_rw, num_ro)) return RK_MASK;
    return RK_NONE;
  endfunction

endpackage

// File: rtl/vme_regbank_evt.sv
// Event status (set by pulses, write-1-to-clear), event mask and the
// registered interrupt derived from them.
module vme_regbank_evt
  import vme_regbank_pkg::*;
#(
  parameter int DATA_WIDTH = 16
) (
  input  logic                  Clk,
  input  logic                  Rst,
  input  logic [DATA_WIDTH-1:0] event_i,
  input  logic [DATA_WIDTH-1:0] evt_clr_i,
  input  logic                  mask_we_i,
  input  logic [DATA_WIDTH-1:0] wr_data_i,
  output logic [DATA_WIDTH-1:0] evt_o,
  output logic [DATA_WIDTH-1:0] mask_o,
  output logic                  irq_o
);

  logic [DATA_WIDTH-1:0] evt_q, evt_d;
  logic [DATA_WIDTH-1:0] mask_q, mask_d;
  logic                  irq_q, irq_d;

  // A new event on the same bit as a clear wins, so no event is lost.
  assign evt_d  = (evt_q & ~evt_clr_i) | event_i;
  assign mask_d = mask_we_i ? wr_data_i : mask_q;
  assign irq_d  = |(evt_q & mask_q);

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      evt_q  <= '0;
      mask_q <= '0;
      irq_q  <= 1'b0;
    end else begin
      evt_q  <= evt_d;
      mask_q <= mask_d;
      irq_q  <= irq_d;
    end
  end

  assign evt_o  = evt_q;
  assign mask_o = mask_q;
  assign irq_o  = irq_q;

endmodule

// File: rtl/vme_regbank.sv
// VME-side register bank: control registers, status words and an event/mask
// pair behind the single-cycle VMERdMem/VMEWrMem strobe bus.
module vme_regbank
  import vme_regbank_pkg::*;
#(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 4,
  parameter int NUM_RW     = 4,
  parameter int NUM_RO     = 4,
  parameter int PIPE_RD    = 0
) (
  input  logic                                         Clk,
  input  logic                                         Rst,
  input  logic [ADDR_WIDTH:1]                          VMEAddr,
  input  logic [DATA_WIDTH-1:0]                        VMEWrData,
  input  logic                                         VMERdMem,
  input  logic                                         VMEWrMem,
  output logic [DATA_WIDTH-1:0]                        VMERdData,
  output logic                                         VMERdDone,
  output logic                                         VMEWrDone,
  output logic [NUM_RW*DATA_WIDTH-1:0]                 ctrl_o,
  output logic [NUM_RW-1:0]                            ctrl_wr_o,
  input  logic [(NUM_RO > 0 ? NUM_RO : 1)*DATA_WIDTH-1:0] status_i,
  input  logic [DATA_WIDTH-1:0]                        event_i,
  output logic                                         irq_o
);

  localparam int unsigned EVT_ADDR = evt_addr(NUM_RW, NUM_RO);

  if (clog2(EVT_ADDR + 2) > ADDR_WIDTH || NUM_RW < 1 || NUM_RW > 8 || NUM_RO > 8)
  begin : g_param_check
    $error("vme_regbank: register map does not fit the parameters");
  end

  logic                               wr_pend_q, wr_done_q;
  logic [ADDR_WIDTH:1]                wr_addr_q;
  logic [DATA_WIDTH-1:0]              wr_data_q;
  logic [NUM_RW-1:0]                  ctrl_wr_q, ctrl_wr_d;
  logic [NUM_RW-1:0][DATA_WIDTH-1:0]  ctrl_q;
  logic [DATA_WIDTH-1:0]              evt_clr_d, evt_w, mask_w;
  logic                               mask_we_d;
  reg_kind_e                          wr_kind, rd_kind;
  logic [DATA_WIDTH-1:0]              rd_mux_d, rd_data_q;
  logic                               rd_done_q;

  assign wr_kind = decode_kind(32'(wr_addr_q), NUM_RW, NUM_RO);

  always_comb begin
    ctrl_wr_d = '0;
    for (int k = 0; k < NUM_RW; k++)
      ctrl_wr_d[k] = wr_pend_q && (wr_kind == RK_CTRL) && (wr_addr_q == ADDR_WIDTH'(k));
  end

  assign evt_clr_d = (wr_pend_q && wr_kind == RK_EVT) ? wr_data_q : '0;
  assign mask_we_d = wr_pend_q && (wr_kind == RK_MASK);

  // Writes land one edge after the strobe is sampled; status and unmapped
  // targets fall through the decode and are simply acked.
  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      wr_pend_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      wr_done_q <= 1'b0;
      ctrl_wr_q <= '0;
      ctrl_q    <= '0;
    end else begin
      wr_pend_q <= VMEWrMem;
      if (VMEWrMem) begin
        wr_addr_q <= VMEAddr;
        wr_data_q <= VMEWrData;
      end
      wr_done_q <= wr_pend_q;
      ctrl_wr_q <= ctrl_wr_d;
      for (int k = 0; k < NUM_RW; k++)
        if (ctrl_wr_d[k]) ctrl_q[k] <= wr_data_q;
    end
  end

  vme_regbank_evt #(.DATA_WIDTH(DATA_WIDTH)) u_evt (
    .Clk       (Clk),
    .Rst       (Rst),
    .event_i   (event_i),
    .evt_clr_i (evt_clr_d),
    .mask_we_i (mask_we_d),
    .wr_data_i (wr_data_q),
    .evt_o     (evt_w),
    .mask_o    (mask_w),
    .irq_o     (irq_o)
  );

  assign rd_kind = decode_kind(32'(VMEAddr), NUM_RW, NUM_RO);

  always_comb begin
    rd_mux_d = '0;
    case (rd_kind)
      RK_CTRL:
        for (int k = 0; k < NUM_RW; k++)
          if (VMEAddr == ADDR_WIDTH'(k)) rd_mux_d = ctrl_q[k];
      RK_STATUS:
        for (int k = 0; k < NUM_RO; k++)
          if (VMEAddr == ADDR_WIDTH'(NUM_RW + k))
            rd_mux_d = status_i[k*DATA_WIDTH +: DATA_WIDTH];
      RK_EVT:  rd_mux_d = evt_w;
      RK_MASK: rd_mux_d = mask_w;
      default: rd_mux_d = '0;
    endcase
  end

  always_ff @(posedge Clk or posedge Rst) begin
    if (Rst) begin
      rd_done_q <= 1'b0;
      rd_data_q <= '0;
    end else begin
      rd_done_q <= VMERdMem;
      if (VMERdMem) rd_data_q <= rd_mux_d;
    end
  end

  if (PIPE_RD != 0) begin : g_rd_pipe
    logic [DATA_WIDTH-1:0] rd2_data_q;
    logic                  rd2_done_q;

    always_ff @(posedge Clk or posedge Rst) begin
      if (Rst) begin
        rd2_done_q <= 1'b0;
        rd2_data_q <= '0;
      end else begin
        rd2_done_q <= rd_done_q;
        if (rd_done_q) rd2_data_q <= rd_data_q;
      end
    end

    assign VMERdData = rd2_data_q;
    assign VMERdDone = rd2_done_q;
  end else begin : g_rd_direct
    assign VMERdData = rd_data_q;
    assign VMERdDone = rd_done_q;
  end

  assign VMEWrDone = wr_done_q;
  assign ctrl_wr_o = ctrl_wr_q;
  assign ctrl_o    = ctrl_q;

endmodule
